// File: rtl/arbiter_weighted_rr.sv
// arbiter_weighted_rr: weighted round-robin arbiter; an owner keeps the grant for up to max(weight,1) back-to-back acks.
// Latency: one cycle from req to gnt (fully registered); handover lands on the cycle after the releasing ack, no bubbles.
// Backpressure: the owner holds gnt until ack; the consumer stalls a transaction simply by withholding ack.
// Ports: clk, rst_n (async active-low); req[N] request vector; weight[N*W] packed per-requester weights;
//        ack completes the current transaction; gnt one-hot grant; gnt_valid = |gnt; gnt_id binary owner index.
module arbiter_weighted_rr #(
    parameter int REQ_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ID_WIDTH     = $clog2(REQ_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [REQ_WIDTH-1:0]              req,
    input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
    input  logic                              ack,
    output logic [REQ_WIDTH-1:0]              gnt,
    output logic                              gnt_valid,
    output logic [ID_WIDTH-1:0]               gnt_id
);

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     owner_q, owner_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic [REQ_WIDTH-1:0]    mask_q, mask_d;
    logic [REQ_WIDTH-1:0]    gnt_q, gnt_d;

    logic [REQ_WIDTH-1:0]    above_mask;
    logic [REQ_WIDTH-1:0]    arb_mask;
    logic [REQ_WIDTH-1:0]    masked_req;
    logic [ID_WIDTH-1:0]     sel;
    logic [WEIGHT_WIDTH-1:0] sel_w;
    logic                    arbitrate;

    // Lowest set bit of v; returns 0 for an all-zero vector (callers guard with |v).
    function automatic logic [ID_WIDTH-1:0] lowest_idx(input logic [REQ_WIDTH-1:0] v);
        logic [ID_WIDTH-1:0] idx;
        idx = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_WIDTH'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        credit_d   = credit_q;
        mask_d     = mask_q;
        gnt_d      = '0;
        arb_mask   = mask_q;
        arbitrate  = 1'b0;
        masked_req = '0;
        sel        = '0;
        sel_w      = '0;
        // Two-step shift keeps the top owner from overflowing the shift amount.
        above_mask = ({REQ_WIDTH{1'b1}} << owner_q) << 1;

        case (state_q)
            ST_IDLE: begin
                // ack is meaningless without an owner and is ignored here.
                arbitrate = |req;
            end
            ST_OWN: begin
                // Release on abort (owner dropped req) or on ack with the burst allowance spent.
                if (!req[owner_q] || (ack && credit_q == '0)) begin
                    mask_d   = above_mask;
                    arb_mask = above_mask;
                    if (|req) begin
                        arbitrate = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ack) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (arbitrate) begin
            masked_req = req & arb_mask;
            // Nothing above the previous owner wants it: wrap to the lowest requester overall.
            sel      = lowest_idx((|masked_req) ? masked_req : req);
            sel_w    = weight[int'(sel)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            owner_d  = sel;
            state_d  = ST_OWN;
            // Weight 0 behaves as 1, so the remaining-credit count saturates at zero.
            credit_d = (sel_w == '0) ? '0 : sel_w - WEIGHT_WIDTH'(1);
        end

        if (state_d == ST_OWN) begin
            gnt_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            credit_q <= '0;
            mask_q   <= {REQ_WIDTH{1'b1}};
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            mask_q   <= mask_d;
            gnt_q    <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    // owner_q is only rewritten on a new grant, so the index holds through IDLE.
    assign gnt_id    = owner_q;

endmodule
